// File: rtl/pipe_hazard_ctrl.sv
// Pipeline sequencing controller: stall/flush/enable generation for a 5-stage core,
// with saturating stall and flush event counters.
//   state | meaning
//   RUN   | normal issue
//   LU    | one load-use bubble just inserted; lu ignored this cycle
//   MWAIT | data memory freeze in progress
module pipe_hazard_ctrl #(
  parameter int          CNT_W     = 32,
  parameter logic [31:0] NOP_INSTR = 32'h00000013
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_use_rs1,
  input  logic             id_use_rs2,
  input  logic             ex_memread,
  input  logic [4:0]       ex_rd,
  input  logic             ex_mispredict,
  input  logic             imem_ready,
  input  logic             dmem_busy,
  input  logic             perf_clr,
  output logic             pc_en,
  output logic             ifid_en,
  output logic             ifid_flush,
  output logic             idex_en,
  output logic             idex_flush,
  output logic             exmem_en,
  output logic [31:0]      nop_instr,
  output logic [1:0]       state,
  output logic [CNT_W-1:0] cnt_stall,
  output logic [CNT_W-1:0] cnt_flush
);

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_LU    = 2'd1,
    ST_MWAIT = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic             w_lu;
  logic             w_flush_evt;
  logic [CNT_W-1:0] r_cnt_stall;
  logic [CNT_W-1:0] r_cnt_flush;

  assign w_lu = ex_memread && (ex_rd != 5'd0) &&
                ((id_use_rs1 && (id_rs1 == ex_rd)) || (id_use_rs2 && (id_rs2 == ex_rd)));

  assign w_flush_evt = !rst && !dmem_busy && ex_mispredict;

  always_comb begin
    w_state_nxt = ST_RUN;
    pc_en       = 1'b0;
    ifid_en     = 1'b0;
    ifid_flush  = 1'b0;
    idex_en     = 1'b0;
    idex_flush  = 1'b0;
    exmem_en    = 1'b0;
    if (!rst) begin
      if (dmem_busy) begin
        w_state_nxt = ST_MWAIT;
      end else if (ex_mispredict) begin
        pc_en      = 1'b1;
        ifid_en    = 1'b1;
        ifid_flush = 1'b1;
        idex_en    = 1'b1;
        idex_flush = 1'b1;
        exmem_en   = 1'b1;
      end else if (w_lu && (r_state != ST_LU)) begin
        idex_en     = 1'b1;
        idex_flush  = 1'b1;
        exmem_en    = 1'b1;
        w_state_nxt = ST_LU;
      end else if (!imem_ready) begin
        ifid_en    = 1'b1;
        ifid_flush = 1'b1;
        idex_en    = 1'b1;
        exmem_en   = 1'b1;
      end else begin
        pc_en    = 1'b1;
        ifid_en  = 1'b1;
        idex_en  = 1'b1;
        exmem_en = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_RUN;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Clear beats increment; both counters stick at all-ones.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt_stall <= '0;
      r_cnt_flush <= '0;
    end else if (perf_clr) begin
      r_cnt_stall <= '0;
      r_cnt_flush <= '0;
    end else begin
      if (!pc_en && (r_cnt_stall != '1)) r_cnt_stall <= r_cnt_stall + CNT_W'(1);
      if (w_flush_evt && (r_cnt_flush != '1)) r_cnt_flush <= r_cnt_flush + CNT_W'(1);
    end
  end

  assign state     = r_state;
  assign cnt_stall = r_cnt_stall;
  assign cnt_flush = r_cnt_flush;
  assign nop_instr = NOP_INSTR;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: directed scenarios plus randomized traffic against a
// rule-level reference model; a 3-bit-counter instance exercises saturation.
module tb_pipe_hazard_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [4:0]  id_rs1 = '0, id_rs2 = '0, ex_rd = '0;
  logic        id_use_rs1 = 0, id_use_rs2 = 0, ex_memread = 0, ex_mispredict = 0;
  logic        imem_ready = 1, dmem_busy = 0, perf_clr = 0;

  logic        pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en;
  logic [31:0] nop_instr;
  logic [1:0]  state;
  logic [31:0] cnt_stall, cnt_flush;

  logic        s_pc_en, s_ifid_en, s_ifid_flush, s_idex_en, s_idex_flush, s_exmem_en;
  logic [31:0] s_nop_instr;
  logic [1:0]  s_state;
  logic [2:0]  s_cnt_stall, s_cnt_flush;

  int checks = 0;
  int errors = 0;

  bit     m_bubble, m_busy;
  longint m_stall, m_flush;
  int     sm_stall, sm_flush;

  always #5 clk = ~clk;

  pipe_hazard_ctrl u_dut (
    .clk(clk), .rst(rst), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .ex_memread(ex_memread),
    .ex_rd(ex_rd), .ex_mispredict(ex_mispredict), .imem_ready(imem_ready),
    .dmem_busy(dmem_busy), .perf_clr(perf_clr), .pc_en(pc_en), .ifid_en(ifid_en),
    .ifid_flush(ifid_flush), .idex_en(idex_en), .idex_flush(idex_flush),
    .exmem_en(exmem_en), .nop_instr(nop_instr), .state(state),
    .cnt_stall(cnt_stall), .cnt_flush(cnt_flush));

  pipe_hazard_ctrl #(.CNT_W(3)) u_sat (
    .clk(clk), .rst(rst), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .ex_memread(ex_memread),
    .ex_rd(ex_rd), .ex_mispredict(ex_mispredict), .imem_ready(imem_ready),
    .dmem_busy(dmem_busy), .perf_clr(perf_clr), .pc_en(s_pc_en), .ifid_en(s_ifid_en),
    .ifid_flush(s_ifid_flush), .idex_en(s_idex_en), .idex_flush(s_idex_flush),
    .exmem_en(s_exmem_en), .nop_instr(s_nop_instr), .state(s_state),
    .cnt_stall(s_cnt_stall), .cnt_flush(s_cnt_flush));

  // Reference: a hazard exists when an enabled source matches a nonzero load target.
  function automatic bit lu_now();
    bit hit1, hit2;
    hit1 = id_use_rs1 && (id_rs1 == ex_rd);
    hit2 = id_use_rs2 && (id_rs2 == ex_rd);
    return ex_memread && (ex_rd != 0) && (hit1 || hit2);
  endfunction

  // {pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en}
  function automatic logic [5:0] exp_out();
    if (rst)                       return 6'b000000;
    if (dmem_busy)                 return 6'b000000;
    if (ex_mispredict)             return 6'b111111;
    if (lu_now() && !m_bubble)     return 6'b000111;
    if (!imem_ready)               return 6'b011101;
    return 6'b110101;
  endfunction

  function automatic logic [5:0] got_out();
    return {pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en};
  endfunction

  function automatic logic [5:0] got_sat_out();
    return {s_pc_en, s_ifid_en, s_ifid_flush, s_idex_en, s_idex_flush, s_exmem_en};
  endfunction

  function automatic logic [1:0] exp_state();
    if (m_busy)   return 2'd2;
    if (m_bubble) return 2'd1;
    return 2'd0;
  endfunction

  task automatic model_clear();
    m_bubble = 0; m_busy = 0; m_stall = 0; m_flush = 0; sm_stall = 0; sm_flush = 0;
  endtask

  task automatic drive(input logic [4:0] rs1, input logic [4:0] rs2, input bit u1,
                       input bit u2, input bit mr, input logic [4:0] rd, input bit mis,
                       input bit imr, input bit busy, input bit clr);
    @(negedge clk);
    id_rs1 = rs1; id_rs2 = rs2; id_use_rs1 = u1; id_use_rs2 = u2;
    ex_memread = mr; ex_rd = rd; ex_mispredict = mis;
    imem_ready = imr; dmem_busy = busy; perf_clr = clr;
    #1;
  endtask

  task automatic drive_idle();
    drive(5'd0, 5'd0, 0, 0, 0, 5'd0, 0, 1, 0, 0);
  endtask

  // Advance one clock, updating the model from the inputs held across the edge.
  task automatic edge_step();
    logic [5:0] e;
    bit nb, nbusy, stall_inc, flush_inc, clr, r;
    e = exp_out();
    r = rst;
    clr = perf_clr;
    stall_inc = (e[5] == 1'b0);
    flush_inc = !dmem_busy && ex_mispredict;
    nbusy = dmem_busy;
    nb = !dmem_busy && !ex_mispredict && lu_now() && !m_bubble;
    @(posedge clk);
    #1;
    if (r) begin
      model_clear();
    end else begin
      m_busy = nbusy;
      m_bubble = nb;
      if (clr) begin
        m_stall = 0; m_flush = 0; sm_stall = 0; sm_flush = 0;
      end else begin
        if (stall_inc) begin
          if (m_stall < 64'hFFFF_FFFF) m_stall++;
          if (sm_stall < 7) sm_stall++;
        end
        if (flush_inc) begin
          if (m_flush < 64'hFFFF_FFFF) m_flush++;
          if (sm_flush < 7) sm_flush++;
        end
      end
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1;
    model_clear();
    drive_idle();
    @(posedge clk);
    #1;
    @(negedge clk);
    rst = 0;
    #1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1;
    model_clear();
    imem_ready = 1; dmem_busy = 0; ex_mispredict = 0;
    @(posedge clk);
    #1;
    checks++;
    if (got_out() !== 6'b000000) begin
      errors++;
      $display("FAIL reset_outputs got=%b want=000000", got_out());
    end
    checks++;
    if (state !== 2'd0 || cnt_stall !== 32'd0 || cnt_flush !== 32'd0) begin
      errors++;
      $display("FAIL reset_state got st=%0d stall=%0d flush=%0d want 0/0/0",
               state, cnt_stall, cnt_flush);
    end
    checks++;
    if (nop_instr !== 32'h00000013) begin
      errors++;
      $display("FAIL nop_instr got=%h want=00000013", nop_instr);
    end
    @(negedge clk);
    rst = 0;
  endtask

  task automatic test_idle();
    do_reset();
    for (int i = 0; i < 10; i++) begin
      drive_idle();
      checks++;
      if (got_out() !== 6'b110101) begin
        errors++;
        $display("FAIL idle_outputs cyc=%0d got=%b want=110101", i, got_out());
      end
      edge_step();
    end
    checks++;
    if (state !== 2'd0 || cnt_stall !== 32'd0 || cnt_flush !== 32'd0) begin
      errors++;
      $display("FAIL idle_counters got st=%0d stall=%0d flush=%0d want 0/0/0",
               state, cnt_stall, cnt_flush);
    end
  endtask

  task automatic test_load_use();
    do_reset();
    drive(5'd1, 5'd5, 0, 1, 1, 5'd5, 0, 1, 0, 0);
    checks++;
    if (pc_en !== 1'b0 || ifid_en !== 1'b0 || idex_flush !== 1'b1 || got_out() !== exp_out()) begin
      errors++;
      $display("FAIL lu_bubble got=%b want=%b", got_out(), exp_out());
    end
    edge_step();
    checks++;
    if (state !== 2'd1) begin
      errors++;
      $display("FAIL lu_state got=%0d want=1", state);
    end
    drive_idle();
    checks++;
    if (got_out() !== 6'b110101) begin
      errors++;
      $display("FAIL lu_release got=%b want=110101", got_out());
    end
    edge_step();
    checks++;
    if (state !== 2'd0 || cnt_stall !== 32'd1) begin
      errors++;
      $display("FAIL lu_count got st=%0d stall=%0d want st=0 stall=1", state, cnt_stall);
    end
    // Held hazard: only one bubble, second cycle proceeds.
    drive(5'd7, 5'd0, 1, 0, 1, 5'd7, 0, 1, 0, 0);
    edge_step();
    checks++;
    if (got_out() !== 6'b110101 || state !== 2'd1) begin
      errors++;
      $display("FAIL lu_double got=%b st=%0d want=110101 st=1", got_out(), state);
    end
    edge_step();
  endtask

  task automatic test_x0();
    do_reset();
    drive(5'd0, 5'd0, 1, 1, 1, 5'd0, 0, 1, 0, 0);
    checks++;
    if (pc_en !== 1'b1 || idex_flush !== 1'b0) begin
      errors++;
      $display("FAIL x0_no_hazard got pc_en=%b idex_flush=%b want 1/0", pc_en, idex_flush);
    end
    edge_step();
    checks++;
    if (cnt_stall !== 32'd0 || state !== 2'd0) begin
      errors++;
      $display("FAIL x0_count got stall=%0d st=%0d want 0/0", cnt_stall, state);
    end
  endtask

  task automatic test_mispredict_lu();
    do_reset();
    drive(5'd3, 5'd0, 1, 0, 1, 5'd3, 1, 1, 0, 0);
    checks++;
    if (got_out() !== 6'b111111) begin
      errors++;
      $display("FAIL mis_lu_out got=%b want=111111", got_out());
    end
    edge_step();
    drive_idle();
    checks++;
    if (got_out() !== 6'b110101 || state !== 2'd0 || cnt_flush !== 32'd1 || cnt_stall !== 32'd0) begin
      errors++;
      $display("FAIL mis_lu_after got=%b st=%0d flush=%0d stall=%0d want 110101/0/1/0",
               got_out(), state, cnt_flush, cnt_stall);
    end
    edge_step();
  endtask

  task automatic test_busy_mispredict();
    do_reset();
    for (int i = 0; i < 3; i++) begin
      drive(5'd0, 5'd0, 0, 0, 0, 5'd0, 1, 1, 1, 0);
      checks++;
      if (got_out() !== 6'b000000) begin
        errors++;
        $display("FAIL busy_freeze cyc=%0d got=%b want=000000", i, got_out());
      end
      edge_step();
    end
    checks++;
    if (state !== 2'd2 || cnt_stall !== 32'd3 || cnt_flush !== 32'd0) begin
      errors++;
      $display("FAIL busy_state got st=%0d stall=%0d flush=%0d want 2/3/0",
               state, cnt_stall, cnt_flush);
    end
    drive(5'd0, 5'd0, 0, 0, 0, 5'd0, 1, 1, 0, 0);
    checks++;
    if (got_out() !== 6'b111111) begin
      errors++;
      $display("FAIL busy_release got=%b want=111111", got_out());
    end
    edge_step();
    checks++;
    if (state !== 2'd0 || cnt_flush !== 32'd1 || cnt_stall !== 32'd3) begin
      errors++;
      $display("FAIL busy_flush got st=%0d flush=%0d stall=%0d want 0/1/3",
               state, cnt_flush, cnt_stall);
    end
  endtask

  task automatic test_saturation();
    do_reset();
    for (int i = 0; i < 10; i++) begin
      drive(5'd0, 5'd0, 0, 0, 0, 5'd0, 0, 0, 0, 0);
      edge_step();
    end
    checks++;
    if (s_cnt_stall !== 3'd7 || cnt_stall !== 32'd10) begin
      errors++;
      $display("FAIL sat_stall got small=%0d wide=%0d want 7/10", s_cnt_stall, cnt_stall);
    end
    drive(5'd0, 5'd0, 0, 0, 0, 5'd0, 0, 0, 0, 1);
    edge_step();
    checks++;
    if (s_cnt_stall !== 3'd0 || cnt_stall !== 32'd0) begin
      errors++;
      $display("FAIL sat_clear got small=%0d wide=%0d want 0/0", s_cnt_stall, cnt_stall);
    end
    for (int i = 0; i < 9; i++) begin
      drive(5'd0, 5'd0, 0, 0, 0, 5'd0, 1, 1, 0, 0);
      edge_step();
    end
    checks++;
    if (s_cnt_flush !== 3'd7 || cnt_flush !== 32'd9) begin
      errors++;
      $display("FAIL sat_flush got small=%0d wide=%0d want 7/9", s_cnt_flush, cnt_flush);
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 600; i++) begin
      drive(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 1'($urandom),
            1'($urandom), 1'($urandom), 5'($urandom_range(0, 3)),
            ($urandom_range(0, 7) == 0), ($urandom_range(0, 4) != 0),
            ($urandom_range(0, 5) == 0), ($urandom_range(0, 60) == 0));
      checks++;
      if (got_out() !== exp_out() || got_sat_out() !== exp_out()) begin
        errors++;
        $display("FAIL rand_out cyc=%0d got=%b sat=%b want=%b", i, got_out(), got_sat_out(), exp_out());
      end
      edge_step();
      checks++;
      if (state !== exp_state() || cnt_stall !== m_stall[31:0] || cnt_flush !== m_flush[31:0] ||
          s_cnt_stall !== sm_stall[2:0] || s_cnt_flush !== sm_flush[2:0]) begin
        errors++;
        $display("FAIL rand_state cyc=%0d got st=%0d st=%0d fl=%0d sst=%0d sfl=%0d want %0d/%0d/%0d/%0d/%0d",
                 i, state, cnt_stall, cnt_flush, s_cnt_stall, s_cnt_flush,
                 exp_state(), m_stall, m_flush, sm_stall, sm_flush);
      end
    end
  endtask

  task automatic test_reset_mid_freeze();
    do_reset();
    for (int i = 0; i < 2; i++) begin
      drive(5'd0, 5'd0, 0, 0, 0, 5'd0, 0, 1, 1, 0);
      edge_step();
    end
    checks++;
    if (state !== 2'd2 || cnt_stall !== 32'd2) begin
      errors++;
      $display("FAIL freeze_pre got st=%0d stall=%0d want 2/2", state, cnt_stall);
    end
    @(negedge clk);
    #2;
    rst = 1;
    #1;
    checks++;
    if (state !== 2'd0 || cnt_stall !== 32'd0 || cnt_flush !== 32'd0 || got_out() !== 6'b000000) begin
      errors++;
      $display("FAIL async_reset got st=%0d stall=%0d flush=%0d out=%b want 0/0/0/000000",
               state, cnt_stall, cnt_flush, got_out());
    end
    model_clear();
    @(negedge clk);
    rst = 0;
    drive_idle();
    edge_step();
    checks++;
    if (state !== 2'd0 || got_out() !== 6'b110101) begin
      errors++;
      $display("FAIL post_reset got st=%0d out=%b want 0/110101", state, got_out());
    end
  endtask

  initial begin
    model_clear();
    test_reset();
    test_idle();
    test_load_use();
    test_x0();
    test_mispredict_lu();
    test_busy_mispredict();
    test_saturation();
    test_random();
    test_reset_mid_freeze();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
Pipeline sequencing controller for the 5-stage RISC-V core.
- Drives the enable and flush controls of the PC, IF/ID, ID/EX and EX/MEM pipeline registers.
- Detects load-use hazards, branch mispredictions (EX-resolved prediction bit P wrong) and instruction/data memory wait states.
- Keeps saturating performance counters of stall and flush events.
- Sits beside the datapath; its outputs feed the IF/ID register enable directly.

Parameters:
CNT_W, 32, width of performance counters
NOP_INSTR, 32'h00000013, instruction word IF/ID loads on flush (addi x0,x0,0)

Ports:
clk  in  1  core clock
rst  in  1  asynchronous reset, active high
id_rs1  in  5  source reg 1 of instruction in ID
id_rs2  in  5  source reg 2 of instruction in ID
id_use_rs1  in  1  ID instruction reads rs1
id_use_rs2  in  1  ID instruction reads rs2
ex_memread  in  1  instruction in EX is a load
ex_rd  in  5  destination reg of instruction in EX
ex_mispredict  in  1  EX branch outcome differs from carried prediction P
imem_ready  in  1  instruction memory returns valid word this cycle
dmem_busy  in  1  data memory not finished; MEM must hold
perf_clr  in  1  synchronous clear of both counters
pc_en  out  1  PC register load enable
ifid_en  out  1  IF/ID enable
ifid_flush  out  1  IF/ID loads NOP_INSTR, P=0 (qualified by ifid_en)
idex_en  out  1  ID/EX enable
idex_flush  out  1  ID/EX loads bubble (all control zero)
exmem_en  out  1  EX/MEM enable
nop_instr  out  32  constant NOP_INSTR for IF/ID mux
state  out  2  FSM state: RUN=0, LU=1, MWAIT=2
cnt_stall  out  CNT_W  cycles with pc_en=0
cnt_flush  out  CNT_W  mispredict flush events

Behaviour:
- Reset (async, rst=1): state=RUN, counters=0.
  - All outputs are combinational from state and inputs, but are forced to pc_en=ifid_en=idex_en=exmem_en=0 and flushes=0 while rst=1.
- Load-use hazard (lu):
  - lu = ex_memread & ex_rd!=0 & ((id_use_rs1 & id_rs1==ex_rd) | (id_use_rs2 & id_rs2==ex_rd)).
  - x0 never hazards.
- Per-cycle output priority, highest first:
  1. dmem_busy=1: full freeze: pc_en=ifid_en=idex_en=exmem_en=0, flushes=0. Next state MWAIT.
  2. ex_mispredict=1: pc_en=1 (PC takes corrected target), ifid_en=1, ifid_flush=1, idex_en=1, idex_flush=1, exmem_en=1. This squashes the 2 wrong-path instructions. Next state RUN. cnt_flush+1.
  3. lu=1 and state!=LU: pc_en=0, ifid_en=0, idex_en=1, idex_flush=1, exmem_en=1. This inserts exactly one bubble. Next state LU.
  4. imem_ready=0: pc_en=0, ifid_en=1, ifid_flush=1 (bubble into ID), rest enabled. Next state RUN.
  5. Otherwise all enables 1, flushes 0. Next state RUN.
- State behaviour:
  - LU: lu is ignored for this one cycle (a guard against a double bubble); otherwise same rules; returns to RUN.
  - MWAIT: stays while dmem_busy=1. On release, the rules are evaluated as in RUN the same cycle. There is no extra dead cycle.
- Simultaneous events:
  - A mispredict during dmem_busy is held (EX frozen) and acted on in the first non-busy cycle.
  - Mispredict together with lu: the flush wins and no bubble cycle is added.
- Counters:
  - cnt_stall increments in every non-reset cycle with pc_en=0.
  - Both counters saturate at all-ones.
  - perf_clr zeroes both at the next edge and has priority over increment.
- Reset mid-freeze: state returns to RUN immediately; counters clear.

Test Plan:
- Reset release, imem_ready=1, no hazards -> all enables 1, flushes 0, state=RUN, counters stay 0 over 10 cycles.
- ex_memread=1, ex_rd=5, id_rs2=5, id_use_rs2=1 for one cycle -> pc_en=0, ifid_en=0, idex_flush=1 for exactly 1 cycle, state LU then RUN, cnt_stall=1.
- Same as the previous case but ex_rd=0 -> no stall, cnt_stall=0.
- ex_mispredict=1 in same cycle as the load-use condition -> ifid_flush=1, idex_flush=1, pc_en=1, cnt_flush=1, no bubble next cycle.
- dmem_busy=1 for 3 cycles with ex_mispredict=1 held -> 3 frozen cycles (state MWAIT, cnt_stall=3), then one flush cycle, cnt_flush=1.
- Preload cnt_stall=2^32-2, imem_ready=0 for 4 cycles -> counter stops at 0xFFFFFFFF; perf_clr=1 -> 0 next edge; rst mid-sequence -> state=0 asynchronously.
